// File: rtl/hd_mask_decoder.sv
// hd_mask_decoder: expands a packed (start, length-1, invert) code word into a
// 32-bit contiguous (wrapping) bit mask, setting one bit per cycle.
module hd_mask_decoder #(
  parameter int unsigned CHECK_RSVD = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_code,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_mask,
  output logic        out_err
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXPAND = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] mask_q,  mask_d;
  logic [4:0]  p_q,     p_d;
  logic [4:0]  c_q,     c_d;
  logic        v_q,     v_d;
  logic        err_q,   err_d;
  logic        live_q;

  // live_q keeps in_ready low through reset and up to the first clock edge.
  assign in_ready  = live_q && (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_HOLD);
  assign out_mask  = out_valid ? (mask_q ^ {32{v_q}}) : '0;
  assign out_err   = out_valid && err_q;

  // Next-state logic: accept in IDLE, set one bit per cycle in EXPAND, hold result.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    p_d     = p_q;
    c_d     = c_q;
    v_d     = v_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          p_d     = in_code[4:0];
          c_d     = in_code[9:5];
          v_d     = in_code[10];
          err_d   = (CHECK_RSVD != 0) && (in_code[15:11] != '0);
          mask_d  = '0;
          state_d = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        mask_d = mask_q | (32'd1 << p_q);
        // 5-bit pointer wraps 31 -> 0 naturally.
        p_d    = p_q + 5'd1;
        if (c_q == '0) begin
          c_d     = '0;
          state_d = ST_HOLD;
        end else begin
          c_d = c_q - 5'd1;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; asynchronous reset aborts any operation in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      p_q     <= '0;
      c_q     <= '0;
      v_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      p_q     <= p_d;
      c_q     <= c_d;
      v_q     <= v_d;
      err_q   <= err_d;
    end
  end

  // Post-reset enable for in_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q <= 1'b0;
    end else begin
      live_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hd_mask_decoder.sv
// Scoreboard bench for hd_mask_decoder: a driver pushes expected results from a
// behavioural mask model; a monitor pops and compares whenever out_valid rises.
module tb_hd_mask_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_code = '0;
  logic        out_ready = 1'b1;
  logic        in_ready, out_valid, out_err;
  logic [31:0] out_mask;
  logic        in_ready0, out_valid0, out_err0;
  logic [31:0] out_mask0;

  typedef struct {
    logic [31:0] mask;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   rdy_mode = 0;  // 0: out_ready=1, 1: random, 2: out_ready=0

  hd_mask_decoder #(.CHECK_RSVD(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .out_valid(out_valid), .out_ready(out_ready),
    .out_mask(out_mask), .out_err(out_err)
  );

  hd_mask_decoder #(.CHECK_RSVD(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_code(in_code), .out_valid(out_valid0), .out_ready(out_ready),
    .out_mask(out_mask0), .out_err(out_err0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, expv, cyc);
  endtask

  // Reference: bit i is set when its distance from s (mod 32) is at most n.
  function automatic logic [31:0] model(input logic [15:0] code);
    int unsigned s = code[4:0];
    int unsigned n = code[9:5];
    logic [31:0] m = '0;
    for (int unsigned i = 0; i < 32; i++)
      if (((i + 32 - s) % 32) <= n) m[i] = 1'b1;
    if (code[10]) m = ~m;
    return m;
  endfunction

  task automatic send(input logic [15:0] code, input bit fixed, input logic [31:0] fmask);
    exp_t e;
    bit   ok = 0;
    @(posedge clk); #1;
    in_code  = code;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      chk(0, "accept_timeout", {31'b0, in_ready}, 32'h1);
      in_valid = 1'b0;
      return;
    end
    e.mask = fixed ? fmask : model(code);
    e.err  = (code[15:11] != '0);
    e.lat  = int'(code[9:5]) + 2;
    e.acc  = cyc;
    sbq.push_back(e);
    // Scramble inputs after acceptance; busy-state in_valid must be ignored.
    @(posedge clk); #1;
    in_valid = 1'($urandom_range(0, 1));
    in_code  = 16'($urandom);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_code  = 16'($urandom);
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (sbq.size() == 0 && !out_valid) begin ok = 1; break; end
    end
    if (!ok) chk(0, "drain_timeout", sbq.size(), 32'h0);
  endtask

  // out_ready driver.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        2:       out_ready = 1'b0;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compares on the first cycle of each result, checks stability while held.
  initial begin
    exp_t        e;
    bit          prev_hold = 0;
    bit          was_xfer = 0;
    logic [31:0] held_mask = '0;
    logic        held_err = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_hold = 0;
        was_xfer  = 0;
      end else begin
        if (was_xfer)
          chk(in_ready && !out_valid, "return_idle", {30'b0, in_ready, out_valid}, 32'h2);
        if (out_valid) begin
          chk(!in_ready, "ready_low_in_hold", {31'b0, in_ready}, 32'h0);
          if (!prev_hold) begin
            if (sbq.size() == 0) begin
              chk(0, "unexpected_output", out_mask, 32'h0);
            end else begin
              e = sbq.pop_front();
              chk(out_mask == e.mask, "mask", out_mask, e.mask);
              chk(out_err == e.err, "err", {31'b0, out_err}, {31'b0, e.err});
              chk((cyc - e.acc) == e.lat, "latency", 32'(cyc - e.acc), 32'(e.lat));
              chk(out_valid0 && out_mask0 == e.mask, "mask_norsvd", out_mask0, e.mask);
              chk(!out_err0, "err_norsvd", {31'b0, out_err0}, 32'h0);
            end
            held_mask = out_mask;
            held_err  = out_err;
          end else begin
            chk(out_mask == held_mask, "hold_mask_stable", out_mask, held_mask);
            chk(out_err == held_err, "hold_err_stable", {31'b0, out_err}, {31'b0, held_err});
          end
        end
        was_xfer  = out_valid && out_ready;
        prev_hold = out_valid && !out_ready;
      end
    end
  end

  // Stimulus.
  initial begin
    bit ok;
    #3;
    chk(!in_ready && !out_valid, "reset_flags", {30'b0, in_ready, out_valid}, 32'h0);
    chk(out_mask == '0 && !out_err, "reset_data", out_mask, 32'h0);
    @(negedge clk); @(negedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk(!in_ready, "ready_before_edge", {31'b0, in_ready}, 32'h0);
    @(negedge clk);
    chk(in_ready, "ready_after_edge", {31'b0, in_ready}, 32'h1);

    rdy_mode = 0;
    send(16'h0043, 1, 32'h0000_0038);
    send(16'h007E, 1, 32'hC000_0003);
    send(16'h07E5, 1, 32'h0000_0000);
    send(16'h8000, 1, 32'h0000_0001);
    drain();

    // Backpressure: hold out_ready low for 10 cycles in HOLD.
    rdy_mode = 2;
    send(16'h0123, 0, '0);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1; break; end
    end
    if (!ok) chk(0, "hold_timeout", {31'b0, out_valid}, 32'h1);
    repeat (10) @(negedge clk);
    rdy_mode = 0;
    drain();

    // Abort mid-EXPAND with an asynchronous reset.
    send(16'h03E0, 0, '0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk(!out_valid && !in_ready && out_mask == '0 && !out_err, "abort_outputs",
        out_mask, 32'h0);
    chk(!out_valid0 && out_mask0 == '0, "abort_outputs_norsvd", out_mask0, 32'h0);
    sbq.delete();
    @(negedge clk); #1;
    rst_n = 1'b1;
    send(16'h0001, 1, 32'h0000_0002);
    drain();

    // Randomized traffic with random backpressure.
    rdy_mode = 1;
    for (int k = 0; k < 40; k++) begin
      if (k % 4 == 0) send(16'($urandom), 0, '0);
      else            send(16'($urandom) & 16'h07FF, 0, '0);
    end
    rdy_mode = 0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
